lsq_ring: RTL and testbench

- Parametrised, age-ordered load-store queue for the out-of-order core.
- Implemented as a circular buffer with head/tail pointers, so age is explicit and entries retire in program order.
- Performs load disambiguation against older stores with unknown addresses.
- Performs width-aware store-to-load forwarding and issues one memory op per cycle to the LSU over a valid/ready handshake.
- Sits between dispatch, the address-generation unit, retirement and the data-memory port.

---
 rtl/lsq_ring.sv | 189 ++++++++++++++++++
 tb/tb_lsq_ring.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_ring.sv
// lsq_ring: age-ordered load-store queue on a circular buffer.
// Oldest-first issue with load disambiguation and store-to-load forwarding.
module lsq_ring #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [PC_W-1:0]          alloc_pc,
  input  logic                     alloc_is_store,
  input  logic                     alloc_byte,
  input  logic [XLEN-1:0]          alloc_data,
  input  logic                     agu_valid,
  input  logic [PC_W-1:0]          agu_pc,
  input  logic [XLEN-1:0]          agu_addr,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [PC_W-1:0]          issue_pc,
  output logic [XLEN-1:0]          issue_addr,
  output logic                     issue_is_store,
  output logic                     issue_byte,
  output logic [XLEN-1:0]          issue_data,
  output logic                     issue_fwd,
  input  logic [1:0]               ret_valid,
  input  logic [PC_W-1:0]          ret_pc0,
  input  logic [PC_W-1:0]          ret_pc1,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    head, tail, cnt;
  logic [DEPTH-1:0] vld, aok, iss, st, bt;
  logic [PC_W-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];

  logic [AW-1:0]    hidx, tidx, h1;
  logic [AW-1:0]    ii, jj, sj, ai, sel_idx, agu_idx;
  logic             ok, s_hit, sel_found, sel_fwd, agu_hit;
  logic             r0, r1, full, do_alloc, do_load, fwd_ok;
  logic [XLEN-1:0]  sel_data;

  assign hidx     = head[AW-1:0];
  assign tidx     = tail[AW-1:0];
  assign h1       = hidx + AW'(1);
  assign cnt      = tail - head;
  assign count    = cnt;
  assign full     = (head ^ tail) == PW'(DEPTH);
  assign alloc_ready = !full;
  assign do_alloc = alloc_valid && !full;
  assign do_load  = !issue_valid || issue_ready;

  // In-order retirement: slot 1 only follows a successful slot 0
  assign r0 = ret_valid[0] && vld[hidx] && iss[hidx] &&
              pc_q[hidx] == ret_pc0;
  assign r1 = r0 && ret_valid[1] && vld[h1] && iss[h1] &&
              pc_q[h1] == ret_pc1;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_fwd   = 1'b0;
    sel_data  = '0;
    ii        = '0;
    jj        = '0;
    sj        = '0;
    ok        = 1'b0;
    s_hit     = 1'b0;
    fwd_ok    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ii    = hidx + AW'(i);
      ok    = (PW'(i) < cnt) && vld[ii] && aok[ii] &&
              !iss[ii] && !sel_found;
      s_hit = 1'b0;
      for (int j = 0; j < i; j++) begin
        jj = hidx + AW'(j);
        if (st[jj]) begin
          if (st[ii]) begin
            if (!iss[jj]) ok = 1'b0;
          end else if (!aok[jj]) begin
            ok = 1'b0;
          end else if (addr_q[jj][XLEN-1:2] ==
                       addr_q[ii][XLEN-1:2]) begin
            s_hit = 1'b1;
            sj    = jj;
          end
        end
      end
      fwd_ok = (!bt[sj] && !bt[ii]) ||
               (bt[sj] && bt[ii] &&
                addr_q[sj][1:0] == addr_q[ii][1:0]);
      if (!st[ii] && s_hit && !fwd_ok) ok = 1'b0;
      if (ok) begin
        sel_found = 1'b1;
        sel_idx   = ii;
        sel_fwd   = !st[ii] && s_hit;
        if (st[ii])
          sel_data = data_q[ii];
        else if (s_hit)
          sel_data = bt[ii] ? XLEN'(data_q[sj][7:0]) : data_q[sj];
      end
    end
  end

  always_comb begin
    agu_hit = 1'b0;
    agu_idx = '0;
    ai      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ai = hidx + AW'(i);
      if (agu_valid && !agu_hit && (PW'(i) < cnt) && vld[ai] &&
          !aok[ai] && pc_q[ai] == agu_pc) begin
        agu_hit = 1'b1;
        agu_idx = ai;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head           <= '0;
      tail           <= '0;
      vld            <= '0;
      aok            <= '0;
      iss            <= '0;
      issue_valid    <= 1'b0;
      issue_pc       <= '0;
      issue_addr     <= '0;
      issue_is_store <= 1'b0;
      issue_byte     <= 1'b0;
      issue_data     <= '0;
      issue_fwd      <= 1'b0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      vld         <= '0;
      aok         <= '0;
      iss         <= '0;
      issue_valid <= 1'b0;
    end else begin
      if (agu_hit) aok[agu_idx] <= 1'b1;
      if (do_load) begin
        issue_valid <= sel_found;
        if (sel_found) begin
          iss[sel_idx]   <= 1'b1;
          issue_pc       <= pc_q[sel_idx];
          issue_addr     <= addr_q[sel_idx];
          issue_is_store <= st[sel_idx];
          issue_byte     <= bt[sel_idx];
          issue_data     <= sel_data;
          issue_fwd      <= sel_fwd;
        end
      end
      if (r0) begin
        vld[hidx] <= 1'b0;
        aok[hidx] <= 1'b0;
        iss[hidx] <= 1'b0;
      end
      if (r1) begin
        vld[h1] <= 1'b0;
        aok[h1] <= 1'b0;
        iss[h1] <= 1'b0;
      end
      if (do_alloc) begin
        vld[tidx] <= 1'b1;
        aok[tidx] <= 1'b0;
        iss[tidx] <= 1'b0;
        tail      <= tail + PW'(1);
      end
      head <= head + PW'(r0) + PW'(r1);
    end
  end

  // Entry payload needs no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (do_alloc && !flush) begin
      pc_q[tidx]   <= alloc_pc;
      st[tidx]     <= alloc_is_store;
      bt[tidx]     <= alloc_byte;
      data_q[tidx] <= alloc_data;
    end
    if (agu_hit && !flush) addr_q[agu_idx] <= agu_addr;
  end
endmodule

// File: tb/tb_lsq_ring.sv
// tb_lsq_ring: random and directed stimulus against a queue-based
// reference model of the load-store queue.
module tb_lsq_ring;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk, rstn, flush;
  logic            alloc_valid, alloc_ready, alloc_is_store, alloc_byte;
  logic [PC_W-1:0] alloc_pc, agu_pc, issue_pc, ret_pc0, ret_pc1;
  logic [XLEN-1:0] alloc_data, agu_addr, issue_addr, issue_data;
  logic            agu_valid, issue_valid, issue_ready;
  logic            issue_is_store, issue_byte, issue_fwd;
  logic [1:0]      ret_valid;
  logic [CW-1:0]   count;

  lsq_ring #(.DEPTH(DEPTH), .XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pc(alloc_pc), .alloc_is_store(alloc_is_store),
    .alloc_byte(alloc_byte), .alloc_data(alloc_data),
    .agu_valid(agu_valid), .agu_pc(agu_pc), .agu_addr(agu_addr),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_addr(issue_addr),
    .issue_is_store(issue_is_store), .issue_byte(issue_byte),
    .issue_data(issue_data), .issue_fwd(issue_fwd),
    .ret_valid(ret_valid), .ret_pc0(ret_pc0), .ret_pc1(ret_pc1),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc, data, addr;
    bit st, bt, aok, iss;
  } ent_t;

  ent_t q[$];
  bit          m_iv, m_st, m_bt, m_fwd;
  logic [31:0] m_pc, m_addr, m_data;
  logic [31:0] next_pc = 32'h1000;

  task automatic model_reset();
    q.delete();
    m_iv = 0; m_st = 0; m_bt = 0; m_fwd = 0;
    m_pc = 0; m_addr = 0; m_data = 0;
  endtask

  // Next state of the queue from the inputs now being driven
  task automatic model_step();
    int sel, r, n0;
    bit fwd;
    logic [31:0] fd;
    if (flush) begin
      q.delete();
      m_iv = 0;
      return;
    end
    n0 = q.size();
    sel = -1; fwd = 0; fd = 0;
    if (!m_iv || issue_ready) begin
      for (int i = 0; i < q.size() && sel < 0; i++) begin
        bit ok, f;
        int s;
        logic [31:0] d;
        if (!q[i].aok || q[i].iss) continue;
        ok = 1; s = -1; f = 0; d = 0;
        for (int j = 0; j < i; j++) begin
          if (!q[j].st) continue;
          if (q[i].st) begin
            if (!q[j].iss) ok = 0;
          end else if (!q[j].aok) ok = 0;
          else if (q[j].addr[31:2] == q[i].addr[31:2]) s = j;
        end
        if (ok && !q[i].st && s >= 0) begin
          if (!q[s].bt && !q[i].bt) begin
            f = 1; d = q[s].data;
          end else if (q[s].bt && q[i].bt &&
                       q[s].addr[1:0] == q[i].addr[1:0]) begin
            f = 1; d = {24'h0, q[s].data[7:0]};
          end else ok = 0;
        end
        if (ok) begin sel = i; fwd = f; fd = d; end
      end
      m_iv = (sel >= 0);
      if (sel >= 0) begin
        m_pc   = q[sel].pc;
        m_addr = q[sel].addr;
        m_st   = q[sel].st;
        m_bt   = q[sel].bt;
        m_fwd  = fwd;
        m_data = q[sel].st ? q[sel].data : fd;
      end
    end
    r = 0;
    if (ret_valid[0] && n0 > 0 && q[0].iss && q[0].pc == ret_pc0) begin
      r = 1;
      if (ret_valid[1] && n0 > 1 && q[1].iss && q[1].pc == ret_pc1)
        r = 2;
    end
    if (sel >= 0) q[sel].iss = 1;
    if (agu_valid) begin
      for (int i = 0; i < q.size(); i++)
        if (q[i].pc == agu_pc && !q[i].aok) begin
          q[i].aok = 1; q[i].addr = agu_addr;
          break;
        end
    end
    for (int k = 0; k < r; k++) void'(q.pop_front());
    if (alloc_valid && n0 < DEPTH) begin
      ent_t e;
      e.pc = alloc_pc; e.data = alloc_data; e.addr = 0;
      e.st = alloc_is_store; e.bt = alloc_byte; e.aok = 0; e.iss = 0;
      q.push_back(e);
    end
  endtask

  task automatic check_outputs();
    chk("alloc_ready", alloc_ready, q.size() < DEPTH);
    chk("count", count, q.size());
    chk("issue_valid", issue_valid, m_iv);
    if (m_iv) begin
      chk("issue_pc", issue_pc, m_pc);
      chk("issue_addr", issue_addr, m_addr);
      chk("issue_is_store", issue_is_store, m_st);
      chk("issue_byte", issue_byte, m_bt);
      chk("issue_data", issue_data, m_data);
      chk("issue_fwd", issue_fwd, m_fwd);
    end
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_pc = 0; alloc_is_store = 0;
    alloc_byte = 0; alloc_data = 0; agu_valid = 0; agu_pc = 0;
    agu_addr = 0; issue_ready = 1; ret_valid = 0; ret_pc0 = 0;
    ret_pc1 = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_alloc(input logic [31:0] pc, input bit s,
                          input bit b, input logic [31:0] d);
    idle();
    alloc_valid = 1; alloc_pc = pc; alloc_is_store = s;
    alloc_byte = b; alloc_data = d;
    cycle();
  endtask

  task automatic do_agu(input logic [31:0] pc, input logic [31:0] a,
                        input bit rdy);
    idle();
    agu_valid = 1; agu_pc = pc; agu_addr = a; issue_ready = rdy;
    cycle();
  endtask

  task automatic do_ret(input logic [31:0] p0, input logic [31:0] p1);
    idle();
    ret_valid = 2'b11; ret_pc0 = p0; ret_pc1 = p1;
    cycle();
  endtask

  task automatic rand_inputs();
    int pend[$];
    idle();
    flush = ($urandom_range(0, 99) == 0);
    alloc_valid = ($urandom_range(0, 2) != 0);
    alloc_pc = next_pc;
    next_pc += 4;
    alloc_is_store = $urandom_range(0, 1);
    alloc_byte = ($urandom_range(0, 2) == 0);
    alloc_data = $urandom;
    for (int i = 0; i < q.size(); i++) if (!q[i].aok) pend.push_back(i);
    agu_valid = $urandom_range(0, 1);
    agu_pc = 32'hFFFF_FFF0;
    agu_addr = 32'h100 + 4 * $urandom_range(0, 2);
    if (pend.size() > 0 && $urandom_range(0, 4) != 0) begin
      int k;
      k = pend[$urandom_range(0, pend.size() - 1)];
      agu_pc = q[k].pc;
      if (q[k].bt) agu_addr += $urandom_range(0, 3);
    end
    issue_ready = ($urandom_range(0, 3) != 0);
    ret_valid = 2'($urandom_range(0, 3));
    ret_pc0 = q.size() > 0 ? q[0].pc : 32'h0;
    ret_pc1 = q.size() > 1 ? q[1].pc : 32'h0;
    if ($urandom_range(0, 5) == 0) begin
      logic [31:0] t;
      t = ret_pc0; ret_pc0 = ret_pc1; ret_pc1 = t;
    end
  endtask

  initial begin
    idle();
    model_reset();
    rstn = 0;
    repeat (2) @(negedge clk);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_data", issue_data, 0);
    chk("rst_issue_pc", issue_pc, 0);
    rstn = 1;

    for (int k = 0; k < 5; k++) do_alloc(32'h10 + 4 * k, 0, 0, 0);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 4);
    do_agu(32'h10, 32'h200, 1);
    do_agu(32'h14, 32'h204, 1);
    idle(); cycle(); cycle();
    do_ret(32'h10, 32'h14);
    chk("ret2_count", count, 2);
    do_alloc(32'h20, 0, 0, 0);
    do_alloc(32'h24, 0, 0, 0);
    chk("wrap_count", count, 4);
    idle(); flush = 1; alloc_valid = 1; alloc_pc = 32'h28;
    cycle();
    chk("flush_count", count, 0);
    chk("flush_iv", issue_valid, 0);

    do_alloc(32'h4, 1, 0, 32'hDEAD_BEEF);
    do_alloc(32'h8, 0, 0, 32'h0);
    do_agu(32'h4, 32'h100, 0);
    do_agu(32'h8, 32'h100, 0);
    chk("sw_first", issue_pc, 32'h4);
    idle(); issue_ready = 0;
    repeat (3) cycle();
    idle(); cycle();
    chk("fwd_pc", issue_pc, 32'h8);
    chk("fwd_flag", issue_fwd, 1);
    chk("fwd_data", issue_data, 32'hDEAD_BEEF);
    do_ret(32'h8, 32'h4);
    chk("bad_order_count", count, 2);
    do_ret(32'h4, 32'h8);
    chk("good_order_count", count, 0);

    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      cycle();
    end

    idle(); flush = 1; cycle();
    do_alloc(32'h40, 1, 0, 32'h55);
    do_agu(32'h40, 32'h300, 0);
    idle(); issue_ready = 0; cycle();
    chk("pre_rst_iv", issue_valid, 1);
    #2 rstn = 0;
    #1;
    chk("async_rst_iv", issue_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_ready", alloc_ready, 1);
    model_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
